// File: rtl/global_types.sv
// Shared stream and verdict types for the frame-inspection datapath.
// Build macro VERDICT_MISS_DROP_EN: frames that get no engine retire as drop (found=1) instead of pass.
package global_types;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } avln_st;

  localparam int VERDICT_SEQ_W = 24;

  typedef struct packed {
    logic                     valid;
    logic                     found;
    logic [VERDICT_SEQ_W-1:0] seq;
  } verdict_t;

`ifdef VERDICT_MISS_DROP_EN
  localparam logic MISS_VERDICT = 1'b1;
`else
  localparam logic MISS_VERDICT = 1'b0;
`endif

endpackage

// File: rtl/verdict_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, as one-hot plus index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  int   cand;
  logic hit;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    hit       = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/verdict_scheduler.sv
// Dispatches frames to shared analysis engines and retires their verdicts in arrival order.
// Build macro VERDICT_MISS_DROP_EN (see global_types) picks the verdict for frames without an engine.
module verdict_scheduler
  import global_types::*;
#(
  parameter int N_ENG     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int SEQ_W     = 24
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  avln_st           in,
  input  logic             clear,
  output logic [N_ENG-1:0] eng_start,
  input  logic [N_ENG-1:0] eng_done,
  input  logic [N_ENG-1:0] eng_found,
  output logic             verdict_valid,
  output logic             verdict_found,
  output logic [SEQ_W-1:0] verdict_seq,
  output logic [15:0]      miss_count,
  output logic             overflow
);

  localparam int AW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int PW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  logic [SEQ_W-1:0]     seq;
  logic [SEQ_W-1:0]     head_seq;
  logic [ROB_DEPTH-1:0] rob_ready;
  logic [ROB_DEPTH-1:0] rob_found;
  logic [N_ENG-1:0]     busy;
  logic [AW-1:0]        eng_idx [N_ENG];
  logic [PW-1:0]        rr_ptr;

  logic [N_ENG-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    rr_next;
  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    tail_idx;
  logic [SEQ_W-1:0] outstanding;
  logic             sop, retire, full, accept;
  logic             unused_in;

  assign unused_in   = ^{in.eop, in.data};
  assign sop         = in.valid & in.sop;
  assign head_idx    = head_seq[AW-1:0];
  assign tail_idx    = seq[AW-1:0];
  assign outstanding = seq - head_seq;
  assign retire      = rob_ready[head_idx];
  // A retiring head frees its slot this same edge, so the buffer only counts as full without one.
  assign full        = (outstanding == SEQ_W'(ROB_DEPTH)) && !retire;
  assign accept      = sop && !full;
  assign rr_next     = (grant_idx == PW'(N_ENG - 1)) ? '0 : grant_idx + 1'b1;

  rr_arbiter #(.N(N_ENG), .PW(PW)) u_arb (
    .req       (~busy),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      seq           <= '0;
      head_seq      <= '0;
      rob_ready     <= '0;
      rob_found     <= '0;
      busy          <= '0;
      rr_ptr        <= '0;
      eng_start     <= '0;
      verdict_valid <= 1'b0;
      verdict_found <= 1'b0;
      verdict_seq   <= '0;
      miss_count    <= '0;
      overflow      <= 1'b0;
      for (int i = 0; i < N_ENG; i++) eng_idx[i] <= '0;
    end else begin
      eng_start     <= '0;
      verdict_valid <= 1'b0;

      if (retire) begin
        verdict_valid       <= 1'b1;
        verdict_found       <= rob_found[head_idx];
        verdict_seq         <= head_seq;
        rob_ready[head_idx] <= 1'b0;
        head_seq            <= head_seq + 1'b1;
      end

      for (int i = 0; i < N_ENG; i++) begin
        if (eng_done[i] && busy[i]) begin
          rob_ready[eng_idx[i]] <= 1'b1;
          rob_found[eng_idx[i]] <= eng_found[i];
          busy[i]               <= 1'b0;
        end
      end

      // Allocation comes after the retire clear: when full, the new frame reuses the retiring slot.
      if (accept) begin
        seq <= seq + 1'b1;
        if (|grant) begin
          eng_start           <= grant;
          busy[grant_idx]     <= 1'b1;
          eng_idx[grant_idx]  <= tail_idx;
          rr_ptr              <= rr_next;
          rob_ready[tail_idx] <= 1'b0;
        end else begin
          rob_ready[tail_idx] <= 1'b1;
          rob_found[tail_idx] <= MISS_VERDICT;
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
        end
      end

      if (sop && full) overflow <= 1'b1;

      if (clear) begin
        miss_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/verdict_scheduler.md
VERDICT_SCHEDULER -- requirements
Module: verdict_scheduler

Interface
REQ-001 SHALL have parameter N_ENG, default 4: number of analysis engines shared between frames.
REQ-002 SHALL have parameter ROB_DEPTH, default 16 (power of 2): in-order verdict buffer entries.
REQ-003 SHALL have parameter SEQ_W, default 24: frame sequence number width.
REQ-004 SHALL have port sys_clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in  in  avln_st  ingress frame stream; sop qualified by valid marks a new frame.
REQ-007 SHALL have port clear  in  1  synchronous clear of status counters and flags.
REQ-008 SHALL have port eng_start  out  N_ENG  one-hot single-cycle start pulse to an engine.
REQ-009 SHALL have port eng_done  in  N_ENG  per-engine completion pulse.
REQ-010 SHALL have port eng_found  in  N_ENG  per-engine result, sampled with eng_done.
REQ-011 SHALL have port verdict_valid  out  1  single-cycle pulse, one per tracked frame, in arrival order.
REQ-012 SHALL have port verdict_found  out  1  1 = drop frame; qualified by verdict_valid.
REQ-013 SHALL have port verdict_seq  out  SEQ_W  sequence number of the retired frame.
REQ-014 SHALL have port miss_count  out  16  saturating count of frames that found no free engine.
REQ-015 SHALL have port overflow  out  1  sticky: a frame arrived with the buffer full.

Function
REQ-016 SHALL assign each in.valid&in.sop frame the current seq (starts 0, +1 per tracked frame, wraps at 2^SEQ_W) and allocate ROB entry seq mod ROB_DEPTH.
REQ-017 SHALL grant the first idle engine at or after rr_ptr (round-robin); rr_ptr <= granted+1 mod N_ENG; eng_start pulses exactly 1 cycle after the sop cycle.
REQ-018 SHALL mark a granted engine busy from grant until its eng_done; SHALL store the frame's ROB index per engine.
REQ-019 On eng_done[i] for a busy engine, SHALL write eng_found[i] and a ready bit into that engine's ROB entry and idle the engine the same edge; multiple simultaneous dones SHALL all be accepted.
REQ-020 SHALL ignore eng_done for an idle engine.
REQ-021 With no idle engine at sop, SHALL allocate the entry as ready immediately with found per REQ-031/032 and increment miss_count (saturate at 0xFFFF).
REQ-022 SHALL retire at most one entry per cycle: if head entry ready (registered), verdict_valid/found/seq asserted next cycle, head advances, entry freed.
REQ-023 A ready bit written on edge t SHALL be retireable no earlier than the verdict at edge t+1 (no same-cycle write-to-retire bypass).
REQ-024 Retire and allocate in the same cycle SHALL both proceed; full = ROB_DEPTH entries outstanding after accounting for a same-cycle retire.
REQ-025 On sop with ROB full, SHALL set overflow, not advance seq, not start an engine, emit no verdict for that frame.
REQ-026 clear SHALL zero miss_count and overflow only; clear and a same-cycle increment SHALL leave miss_count 0.

Reset
REQ-027 reset_n low SHALL asynchronously zero seq, head, rr_ptr, all busy/ready bits, eng_start, verdict_valid, verdict_found, verdict_seq, miss_count, overflow.
REQ-028 Reset mid-operation SHALL discard all outstanding frames without verdicts; dones arriving after reset release SHALL be ignored per REQ-020.

Configuration
REQ-029 Macro VERDICT_MISS_DROP_EN SHALL select the verdict for frames without an engine.
REQ-030 Only this feature SHALL be macro-controlled.
REQ-031 Defined: unassigned frames SHALL retire with verdict_found=1 (fail-closed).
REQ-032 Undefined: unassigned frames SHALL retire with verdict_found=0 (fail-open).

Structure
REQ-033 avln_st SHALL remain in global_types; a verdict_t struct {valid, found, seq} SHALL be added to global_types.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant, grant index).

Verification
REQ-035 Single frame, engine 0 done after 5 cycles with found=1 -> eng_start=0001 one cycle after sop; verdict_valid, found=1, seq=0 one cycle after done.
REQ-036 Frames 0,1 to engines 0,1; engine 1 done first (found=0), engine 0 later (found=1) -> verdicts in order seq0 found1, seq1 found0, consecutive cycles.
REQ-037 5 frames back-to-back, N_ENG=4, no dones -> grants 0,1,2,3; frame 4 miss_count=1; after all dones, seq 4 retires last with found=0 (=1 with VERDICT_MISS_DROP_EN).
REQ-038 17 frames, ROB_DEPTH=16, no dones -> overflow=1 on 17th, seq stays 16; clear -> overflow=0, miss_count=0.
REQ-039 Reset asserted with 3 outstanding frames, then late eng_done -> no verdict_valid, all outputs 0, next frame gets seq 0 on engine 0.
